pipe_stage_skid: RTL and testbench

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

---
 rtl/pipe_stage_skid.sv | 77 +++++++
 tb/tb_pipe_stage_skid.sv | 132 +++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: two-entry skid-buffered pipeline stage with bubble-zeroed control and saturating stall counter
module pipe_stage_skid #(
  parameter int DATA_W = 141,
  parameter int CTRL_W = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);
  localparam int EW = CTRL_W + DATA_W;
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_e;
  state_e state_q, state_d;
  logic [EW-1:0] main_q, main_d, skid_q, skid_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic acc, con;
  assign in_ready  = state_q != FULL;
  assign out_valid = state_q != EMPTY;
  assign occupancy = state_q;
  assign out_ctrl  = out_valid ? main_q[EW-1:DATA_W] : '0;
  assign out_data  = main_q[DATA_W-1:0];
  assign stall_cnt = stall_q;
  assign acc = in_valid & in_ready;
  assign con = out_valid & out_ready;
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    stall_d = (out_valid & ~out_ready & ~&stall_q) ? stall_q + 1'b1 : stall_q;
    case (state_q)
      EMPTY: if (acc) begin
        state_d = ONE;
        main_d  = {in_ctrl, in_data};
      end
      ONE: if (acc & con) main_d = {in_ctrl, in_data};
        else if (acc) begin
          state_d = FULL;
          skid_d  = {in_ctrl, in_data};
        end
        else if (con) state_d = EMPTY;
      FULL: if (con) begin
        state_d = ONE;
        main_d  = skid_q;
      end
      default: state_d = EMPTY;
    endcase
    // flushed entries must never reach out_data, so storage is frozen too
    if (flush) begin
      state_d = EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      stall_q <= stall_d;
    end
  end
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: table-driven and scoreboard check of the skid stage against a queue model
module tb_pipe_stage_skid;
  localparam int DW = 141;
  logic clk = 0;
  logic rst = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic [1:0] in_ctrl = '0;
  logic [DW-1:0] in_data = '0;
  logic in_ready, out_valid, s_in_ready, s_out_valid;
  logic [1:0] out_ctrl, occupancy, s_out_ctrl, s_occupancy, s_stall;
  logic [DW-1:0] out_data, s_out_data;
  logic [15:0] stall_cnt;
  always #5 clk = ~clk;
  pipe_stage_skid u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
    .in_data(in_data), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_data(out_data), .occupancy(occupancy), .stall_cnt(stall_cnt)
  );
  pipe_stage_skid #(.CNT_W(2)) u_small (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .in_ctrl(in_ctrl),
    .in_data(in_data), .flush(flush), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_ctrl(s_out_ctrl), .out_data(s_out_data), .occupancy(s_occupancy), .stall_cnt(s_stall)
  );
  typedef struct {logic [1:0] c; logic [DW-1:0] d;} ent_t;
  typedef struct {logic r, f, iv; logic [1:0] c; logic [DW-1:0] d; logic ordy; logic [1:0] occ;} vec_t;
  ent_t eq[$];
  vec_t tbl[$];
  logic [DW-1:0] last_d = '0;
  logic [15:0] st16 = '0;
  logic [1:0] st2 = '0;
  int nvec = 0, nerr = 0;
  task automatic chk(input string n, input logic [255:0] a, input logic [255:0] e);
    nvec++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  task automatic add(input logic r, f, iv, input logic [1:0] c, input logic [DW-1:0] d,
                     input logic ordy, input logic [1:0] occ);
    vec_t v;
    v.r = r; v.f = f; v.iv = iv; v.c = c; v.d = d; v.ordy = ordy; v.occ = occ;
    tbl.push_back(v);
  endtask
  task automatic cycle(input logic r, f, iv, input logic [1:0] c, input logic [DW-1:0] d, input logic ordy);
    ent_t e;
    int sz;
    @(negedge clk);
    rst = r; flush = f; in_valid = iv; in_ctrl = c; in_data = d; out_ready = ordy;
    #1;
    sz = eq.size();
    chk("in_ready", in_ready, sz < 2);
    chk("out_valid", out_valid, sz > 0);
    chk("occupancy", occupancy, sz);
    chk("stall_cnt", stall_cnt, st16);
    chk("small_stall", s_stall, st2);
    if (sz > 0) begin
      chk("out_ctrl", out_ctrl, eq[0].c);
      chk("out_data", out_data, eq[0].d);
    end else begin
      chk("out_ctrl_bubble", out_ctrl, 0);
      chk("out_data_hold", out_data, last_d);
    end
    if (r) begin
      eq.delete();
      last_d = '0; st16 = '0; st2 = '0;
    end else begin
      if (sz > 0 && !ordy) begin
        if (st16 != 16'hffff) st16++;
        if (st2 != 2'd3) st2++;
      end
      if (sz > 0 && ordy) begin
        e = eq.pop_front();
        chk("deliver", {out_ctrl, out_data}, {e.c, e.d});
      end
      if (iv && sz < 2 && !f) begin
        e.c = c; e.d = d;
        eq.push_back(e);
      end
      if (f) eq.delete();
      if (eq.size() > 0) last_d = eq[0].d;
    end
    @(posedge clk);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    logic [159:0] rnd;
    add(1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 2'b01, 'h5, 1, 1);
    add(0, 0, 0, 0, 0, 1, 0);
    for (int i = 1; i <= 8; i++) add(0, 0, 1, 2'(i), DW'(i), 1, 1);
    add(0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 1, 2'b11, 'hA, 0, 1);
    add(0, 0, 1, 2'b10, 'hB, 0, 2);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 0, 0, 2);
    add(0, 0, 0, 0, 0, 1, 1);
    add(0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 1, 2'b11, 'h11, 0, 1);
    add(0, 0, 1, 2'b11, 'h12, 0, 2);
    add(0, 1, 1, 2'b11, 'hC, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 1, 2'b01, 'h21, 0, 1);
    add(0, 1, 1, 2'b11, 'hC, 1, 0);
    add(0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 1, 2'b11, 'h31, 0, 1);
    add(0, 0, 1, 2'b11, 'h32, 0, 2);
    add(1, 1, 1, 2'b11, 'hC, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0);
    foreach (tbl[i]) begin
      cycle(tbl[i].r, tbl[i].f, tbl[i].iv, tbl[i].c, tbl[i].d, tbl[i].ordy);
      #1 chk($sformatf("occ_vec%0d", i), occupancy, tbl[i].occ);
    end
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 0, 1, 2'b10, 'h77, 0);
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0, 0, 0);
    #1;
    chk("sat_small", s_stall, 3);
    chk("stall_six", stall_cnt, 6);
    for (int i = 0; i < 400; i++) begin
      rnd = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      cycle($urandom_range(0, 99) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0,
            2'($urandom_range(0, 3)), rnd[DW-1:0], $urandom_range(0, 2) != 0);
    end
    cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 1);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
